// File: rtl/stream_parity_checker.sv
// Receive-side parity checker: folds framed N-bit beats into a running XOR and,
// on the last beat, checks it against the transmitted parity bit.
module stream_parity_checker #(
  parameter int N          = 8,
  parameter bit PARITY_ODD = 1'b0,
  parameter int CW         = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [N-1:0]  s_data,
  input  logic          s_last,
  input  logic          s_parity,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_error,
  output logic [CW-1:0] m_beats,
  output logic          m_sat
);

  typedef enum logic {ACCUM = 1'b0, RESULT = 1'b1} state_e;

  localparam logic [CW-1:0] CNT_MAX = '1;

  state_e          state_q, state_d;
  logic            ready_q, ready_d;
  logic            acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sat_q, sat_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [CW-1:0]   beats_q, beats_d;
  logic            msat_q, msat_d;

  logic            accept;
  logic            acc_next;
  logic [CW-1:0]   cnt_inc;
  logic            cnt_ovf;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  assign s_ready = ready_q;
  assign m_valid = valid_q;
  assign m_error = err_q;
  assign m_beats = beats_q;
  assign m_sat   = msat_q;

  assign accept  = s_valid & ready_q;
  assign cnt_ovf = (cnt_q == CNT_MAX);
  assign cnt_inc = sat_inc(cnt_q);

  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    valid_d  = valid_q;
    err_d    = err_q;
    beats_d  = beats_q;
    msat_d   = msat_q;
    acc_next = acc_q;

    case (state_q)
      ACCUM: begin
        ready_d = 1'b1;
        if (accept) begin
          // s_data is only reduced under accept so idle X never reaches acc
          acc_next = acc_q ^ (^s_data);
          if (s_last) begin
            err_d   = acc_next ^ s_parity ^ PARITY_ODD;
            beats_d = cnt_inc;
            msat_d  = sat_q | cnt_ovf;
            valid_d = 1'b1;
            ready_d = 1'b0;
            state_d = RESULT;
          end else begin
            acc_d = acc_next;
            cnt_d = cnt_inc;
            sat_d = sat_q | cnt_ovf;
          end
        end
      end
      RESULT: begin
        ready_d = 1'b0;
        if (m_ready) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          acc_d   = 1'b0;
          cnt_d   = '0;
          sat_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
        ready_d = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      ready_q <= 1'b0;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      beats_q <= '0;
      msat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      beats_q <= beats_d;
      msat_q  <= msat_d;
    end
  end

endmodule
